// File: rtl/exe_stage_mc_pkg.sv
// Shared definitions for the multi-cycle execute stage: memory access sizes,
// ALU opcode bit positions, bus field widths and the divider state encoding.
package exe_pkg;

  localparam logic [1:0] MEM_B = 2'd0;
  localparam logic [1:0] MEM_H = 2'd1;
  localparam logic [1:0] MEM_W = 2'd2;

  localparam int ALU_OP_W   = 12;
  localparam int DEST_W     = 5;
  localparam int MEM_SIZE_W = 2;

  // One-hot bit positions inside alu_op
  localparam int OP_ADD  = 0;
  localparam int OP_SUB  = 1;
  localparam int OP_SLT  = 2;
  localparam int OP_SLTU = 3;
  localparam int OP_AND  = 4;
  localparam int OP_NOR  = 5;
  localparam int OP_OR   = 6;
  localparam int OP_XOR  = 7;
  localparam int OP_SLL  = 8;
  localparam int OP_SRL  = 9;
  localparam int OP_SRA  = 10;
  localparam int OP_LUI  = 11;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } div_state_e;

endpackage

// File: rtl/exe_stage_mc_div_iter.sv
// Iterative restoring divider: one quotient bit per cycle on operand magnitudes,
// signs and the divide-by-zero result are applied when the result is read.
module div_iter
  import exe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_i,
  input  logic            signed_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            ack_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  div_state_e      state_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] quo_q, rem_q, b_abs_q, a_q;
  logic            neg_q_q, neg_r_q, b_zero_q;

  logic [XLEN-1:0] a_abs, b_abs, rem_d;
  logic [XLEN:0]   trial, diff;
  logic            ge;

  assign a_abs = (signed_i && a_i[XLEN-1]) ? -a_i : a_i;
  assign b_abs = (signed_i && b_i[XLEN-1]) ? -b_i : b_i;

  // quo_q starts as the dividend and shifts quotient bits in from the right
  assign trial = {rem_q, quo_q[XLEN-1]};
  assign diff  = trial - {1'b0, b_abs_q};
  assign ge    = ~diff[XLEN];
  assign rem_d = ge ? diff[XLEN-1:0] : trial[XLEN-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      b_abs_q  <= '0;
      a_q      <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      b_zero_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start_i) begin
          state_q  <= BUSY;
          cnt_q    <= '0;
          quo_q    <= a_abs;
          rem_q    <= '0;
          b_abs_q  <= b_abs;
          a_q      <= a_i;
          neg_q_q  <= signed_i && (a_i[XLEN-1] ^ b_i[XLEN-1]);
          neg_r_q  <= signed_i && a_i[XLEN-1];
          b_zero_q <= (b_i == '0);
        end
        BUSY: begin
          quo_q <= {quo_q[XLEN-2:0], ge};
          rem_q <= rem_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) state_q <= DONE;
        end
        DONE: if (ack_i) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o      = (state_q == BUSY);
  assign done_o      = (state_q == DONE);
  assign quotient_o  = b_zero_q ? '1  : (neg_q_q ? -quo_q : quo_q);
  assign remainder_o = b_zero_q ? a_q : (neg_r_q ? -rem_q : rem_q);

endmodule

// File: rtl/exe_stage_mc.sv
// Execute stage with iterative divider, aligned stores and req/addr_ok SRAM handshake.
// Define EXE_FWD_EN to add the es_fwd_bus bypass output towards ID.
module exe_stage_mc
  import exe_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int DS_BUS_W = 4*XLEN + 28,
  parameter int MS_BUS_W = 2*XLEN + 13
) (
  input  logic                clk,
  input  logic                reset,
`ifdef EXE_FWD_EN
  output logic [XLEN+6:0]     es_fwd_bus,
`endif
  input  logic                ms_allowin,
  output logic                es_allowin,
  input  logic                ds_to_es_valid,
  input  logic [DS_BUS_W-1:0] ds_to_es_bus,
  output logic                es_to_ms_valid,
  output logic [MS_BUS_W-1:0] es_to_ms_bus,
  output logic                data_sram_req,
  output logic                data_sram_wr,
  output logic [3:0]          data_sram_wstrb,
  output logic [XLEN-1:0]     data_sram_addr,
  output logic [XLEN-1:0]     data_sram_wdata,
  input  logic                data_sram_addr_ok
);

  localparam int SHW = $clog2(XLEN);

  logic                es_valid_q, es_valid_d;
  logic [DS_BUS_W-1:0] ds_bus_q, ds_bus_d;
  logic                req_done_q, req_done_d;

  logic [ALU_OP_W-1:0]   alu_op;
  logic                  src1_is_pc, src2_is_imm;
  logic [XLEN-1:0]       pc, rj_value, imm, rkd_value;
  logic                  gr_we, res_from_mem, mem_we, mem_unsigned;
  logic [DEST_W-1:0]     dest;
  logic [MEM_SIZE_W-1:0] mem_size;
  logic                  is_div, div_signed, div_mod;

  assign {alu_op, src1_is_pc, pc, rj_value, src2_is_imm, imm, rkd_value, gr_we, dest,
          res_from_mem, mem_we, mem_size, mem_unsigned, is_div, div_signed, div_mod} = ds_bus_q;

  logic [XLEN-1:0] src1, src2, alu_result, es_result;
  logic [SHW-1:0]  shamt;
  logic            mem_access, ale, mem_ready, es_ready_go, es_leave;
  logic            div_start, div_busy, div_done;
  logic [XLEN-1:0] div_quo, div_rem;

  // Same one-hot ALU as the previous pipeline generation
  always_comb begin
    src1       = src1_is_pc  ? pc  : rj_value;
    src2       = src2_is_imm ? imm : rkd_value;
    shamt      = src2[SHW-1:0];
    alu_result = '0;
    if (alu_op[OP_ADD])  alu_result |= src1 + src2;
    if (alu_op[OP_SUB])  alu_result |= src1 - src2;
    if (alu_op[OP_SLT])  alu_result |= {{(XLEN-1){1'b0}}, $signed(src1) < $signed(src2)};
    if (alu_op[OP_SLTU]) alu_result |= {{(XLEN-1){1'b0}}, src1 < src2};
    if (alu_op[OP_AND])  alu_result |= src1 & src2;
    if (alu_op[OP_NOR])  alu_result |= ~(src1 | src2);
    if (alu_op[OP_OR])   alu_result |= src1 | src2;
    if (alu_op[OP_XOR])  alu_result |= src1 ^ src2;
    if (alu_op[OP_SLL])  alu_result |= src1 << shamt;
    if (alu_op[OP_SRL])  alu_result |= src1 >> shamt;
    if (alu_op[OP_SRA])  alu_result |= $unsigned($signed(src1) >>> shamt);
    if (alu_op[OP_LUI])  alu_result |= src2;
  end

  assign mem_access = res_from_mem || mem_we;
  assign ale = mem_access && (((mem_size == MEM_H) && alu_result[0]) ||
                              ((mem_size == MEM_W) && (alu_result[1:0] != 2'b00)));

  always_comb begin
    data_sram_wstrb = 4'b0000;
    data_sram_wdata = rkd_value;
    case (mem_size)
      MEM_B: begin
        data_sram_wstrb = 4'b0001 << alu_result[1:0];
        data_sram_wdata = {(XLEN/8){rkd_value[7:0]}};
      end
      MEM_H: begin
        data_sram_wstrb = 4'b0011 << alu_result[1:0];
        data_sram_wdata = {(XLEN/16){rkd_value[15:0]}};
      end
      default: data_sram_wstrb = 4'b1111;
    endcase
    if (!mem_we) data_sram_wstrb = 4'b0000;
  end

  assign data_sram_req  = es_valid_q && mem_access && !ale && !req_done_q && ms_allowin;
  assign data_sram_wr   = mem_we;
  assign data_sram_addr = alu_result;
  assign mem_ready      = ale || req_done_q || (data_sram_req && data_sram_addr_ok);

  assign div_start = es_valid_q && is_div && !div_done && !div_busy;

  div_iter #(.XLEN(XLEN)) u_div_iter (
    .clk         (clk),
    .reset       (reset),
    .start_i     (div_start),
    .signed_i    (div_signed),
    .a_i         (rj_value),
    .b_i         (rkd_value),
    .ack_i       (es_leave),
    .busy_o      (div_busy),
    .done_o      (div_done),
    .quotient_o  (div_quo),
    .remainder_o (div_rem)
  );

  assign es_ready_go    = is_div ? div_done : (mem_access ? mem_ready : 1'b1);
  assign es_allowin     = !es_valid_q || (es_ready_go && ms_allowin);
  assign es_to_ms_valid = es_valid_q && es_ready_go;
  assign es_leave       = es_to_ms_valid && ms_allowin;
  assign es_result      = is_div ? (div_mod ? div_rem : div_quo) : alu_result;

  assign es_to_ms_bus = {ale, mem_size, mem_unsigned, alu_result[1:0], res_from_mem,
                         gr_we, dest, es_result, pc};

`ifdef EXE_FWD_EN
  assign es_fwd_bus = {es_valid_q && gr_we, es_ready_go && !res_from_mem, dest, es_result};
`endif

  // An accepted request is remembered so it is not reissued while MEM stalls us
  always_comb begin
    es_valid_d = es_allowin ? ds_to_es_valid : es_valid_q;
    ds_bus_d   = (ds_to_es_valid && es_allowin) ? ds_to_es_bus : ds_bus_q;
    req_done_d = req_done_q;
    if (es_leave)                                 req_done_d = 1'b0;
    else if (data_sram_req && data_sram_addr_ok)  req_done_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      es_valid_q <= 1'b0;
      ds_bus_q   <= '0;
      req_done_q <= 1'b0;
    end else begin
      es_valid_q <= es_valid_d;
      ds_bus_q   <= ds_bus_d;
      req_done_q <= req_done_d;
    end
  end

endmodule

// File: tb/tb_exe_stage_mc.sv
// Directed self-checking bench for exe_stage_mc: ALU, store alignment, misalignment,
// SRAM handshake timing, divider results/latency and reset during a divide.
module tb_exe_stage_mc;

  localparam int XLEN     = 32;
  localparam int DS_BUS_W = 4*XLEN + 28;
  localparam int MS_BUS_W = 2*XLEN + 13;

  logic                clk;
  logic                reset;
  logic                ms_allowin;
  logic                es_allowin;
  logic                ds_to_es_valid;
  logic [DS_BUS_W-1:0] ds_to_es_bus;
  logic                es_to_ms_valid;
  logic [MS_BUS_W-1:0] es_to_ms_bus;
  logic                data_sram_req;
  logic                data_sram_wr;
  logic [3:0]          data_sram_wstrb;
  logic [XLEN-1:0]     data_sram_addr;
  logic [XLEN-1:0]     data_sram_wdata;
  logic                data_sram_addr_ok;
`ifdef EXE_FWD_EN
  logic [XLEN+6:0]     es_fwd_bus;
`endif

  exe_stage_mc #(.XLEN(XLEN)) dut (
    .clk               (clk),
    .reset             (reset),
`ifdef EXE_FWD_EN
    .es_fwd_bus        (es_fwd_bus),
`endif
    .ms_allowin        (ms_allowin),
    .es_allowin        (es_allowin),
    .ds_to_es_valid    (ds_to_es_valid),
    .ds_to_es_bus      (ds_to_es_bus),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_to_ms_bus      (es_to_ms_bus),
    .data_sram_req     (data_sram_req),
    .data_sram_wr      (data_sram_wr),
    .data_sram_wstrb   (data_sram_wstrb),
    .data_sram_addr    (data_sram_addr),
    .data_sram_wdata   (data_sram_wdata),
    .data_sram_addr_ok (data_sram_addr_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int assertCount = 0;
  int failCount   = 0;

  localparam logic [11:0] OP_ADD = 12'h001;
  localparam logic [11:0] OP_SUB = 12'h002;
  localparam logic [31:0] TB_PC  = 32'h1c00_0100;

  function automatic logic [DS_BUS_W-1:0] makeDs(
    input logic [11:0] op, input logic [31:0] rj, input logic srcImm, input logic [31:0] imm,
    input logic [31:0] rkd, input logic grWe, input logic [4:0] dest, input logic resMem,
    input logic memWe, input logic [1:0] size, input logic isDiv, input logic divSigned,
    input logic divMod);
    return {op, 1'b0, TB_PC, rj, srcImm, imm, rkd, grWe, dest, resMem, memWe, size, 1'b0,
            isDiv, divSigned, divMod};
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Presents one instruction for a single accepting edge; returns at mid-cycle 0 in EXE
  task automatic applyStimulus(input logic [DS_BUS_W-1:0] bus);
    @(negedge clk);
    ds_to_es_valid = 1'b1;
    ds_to_es_bus   = bus;
    @(negedge clk);
    ds_to_es_valid = 1'b0;
    ds_to_es_bus   = '0;
    #1;
  endtask

  task automatic runDiv(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic sgn, input logic modSel, input logic [31:0] expected);
    int cyc;
    applyStimulus(makeDs(12'h000, a, 1'b0, 32'h0, b, 1'b1, 5'd7, 1'b0, 1'b0, 2'd0,
                         1'b1, sgn, modSel));
    checkOutput({tag, "_stall"}, 128'(es_allowin), 128'(1'b0));
    cyc = 0;
    while (!es_to_ms_valid && cyc < 100) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    checkOutput({tag, "_latency"}, 128'(cyc), 128'(33));
    checkOutput({tag, "_result"}, 128'(es_to_ms_bus[63:32]), 128'(expected));
    @(negedge clk);
    #1;
    checkOutput({tag, "_gone"}, 128'(es_to_ms_valid), 128'(1'b0));
  endtask

  initial begin
    int reqCycles;
    reset             = 1'b1;
    ms_allowin        = 1'b1;
    ds_to_es_valid    = 1'b0;
    ds_to_es_bus      = '0;
    data_sram_addr_ok = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_allowin", 128'(es_allowin), 128'(1'b1));
    checkOutput("rst_valid",   128'(es_to_ms_valid), 128'(1'b0));
    checkOutput("rst_bus",     128'(es_to_ms_bus), 128'(0));
    checkOutput("rst_sram",    128'({data_sram_req, data_sram_wr, data_sram_wstrb,
                                     data_sram_addr, data_sram_wdata}), 128'(0));
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] ADD / SUB one-cycle latency");
    applyStimulus(makeDs(OP_ADD, 32'd5, 1'b0, 32'h0, 32'd7, 1'b1, 5'd3, 1'b0, 1'b0, 2'd2,
                         1'b0, 1'b0, 1'b0));
    checkOutput("add_valid",  128'(es_to_ms_valid), 128'(1'b1));
    checkOutput("add_result", 128'(es_to_ms_bus[63:32]), 128'(32'd12));
    checkOutput("add_pc",     128'(es_to_ms_bus[31:0]), 128'(TB_PC));
    checkOutput("add_dest",   128'(es_to_ms_bus[68:64]), 128'(5'd3));
    checkOutput("add_req",    128'(data_sram_req), 128'(1'b0));
    applyStimulus(makeDs(OP_SUB, 32'd5, 1'b0, 32'h0, 32'd7, 1'b1, 5'd4, 1'b0, 1'b0, 2'd2,
                         1'b0, 1'b0, 1'b0));
    checkOutput("sub_result", 128'(es_to_ms_bus[63:32]), 128'(32'hFFFF_FFFE));
    @(negedge clk);
    #1;
    checkOutput("sub_gone", 128'(es_to_ms_valid), 128'(1'b0));

    $display("[TB] store byte with delayed addr_ok");
    applyStimulus(makeDs(OP_ADD, 32'h1000, 1'b1, 32'h3, 32'h0000_00AB, 1'b0, 5'd0, 1'b0,
                         1'b1, 2'd0, 1'b0, 1'b0, 1'b0));
    reqCycles = 0;
    checkOutput("sb_wstrb", 128'(data_sram_wstrb), 128'(4'b1000));
    checkOutput("sb_wdata", 128'(data_sram_wdata), 128'(32'hABAB_ABAB));
    checkOutput("sb_addr",  128'(data_sram_addr), 128'(32'h1003));
    checkOutput("sb_wr",    128'(data_sram_wr), 128'(1'b1));
    for (int c = 0; c < 3; c++) begin
      if (c != 0) begin
        @(negedge clk);
        #1;
      end
      if (data_sram_req) reqCycles++;
      checkOutput($sformatf("sb_allowin_c%0d", c), 128'(es_allowin), 128'(1'b0));
    end
    @(negedge clk);
    data_sram_addr_ok = 1'b1;
    #1;
    if (data_sram_req) reqCycles++;
    checkOutput("sb_req_cycles", 128'(reqCycles), 128'(4));
    checkOutput("sb_accept_valid", 128'(es_to_ms_valid), 128'(1'b1));
    checkOutput("sb_accept_allowin", 128'(es_allowin), 128'(1'b1));
    checkOutput("sb_addr_lo", 128'(es_to_ms_bus[72:71]), 128'(2'd3));
    @(negedge clk);
    data_sram_addr_ok = 1'b0;
    #1;
    checkOutput("sb_after_req", 128'({data_sram_req, es_to_ms_valid}), 128'(2'b00));

    $display("[TB] store word accepted in the request cycle");
    @(negedge clk);
    data_sram_addr_ok = 1'b1;
    applyStimulus(makeDs(OP_ADD, 32'h1000, 1'b1, 32'h4, 32'h1234_5678, 1'b0, 5'd0, 1'b0,
                         1'b1, 2'd2, 1'b0, 1'b0, 1'b0));
    checkOutput("sw_wstrb", 128'(data_sram_wstrb), 128'(4'b1111));
    checkOutput("sw_wdata", 128'(data_sram_wdata), 128'(32'h1234_5678));
    checkOutput("sw_valid", 128'({data_sram_req, es_to_ms_valid}), 128'(2'b11));
    @(negedge clk);
    data_sram_addr_ok = 1'b1;
    #1;
    checkOutput("sw_no_reissue", 128'(data_sram_req), 128'(1'b0));
    data_sram_addr_ok = 1'b0;

    $display("[TB] misaligned half store and word load");
    applyStimulus(makeDs(OP_ADD, 32'h1000, 1'b1, 32'h1, 32'h0000_BEEF, 1'b0, 5'd0, 1'b0,
                         1'b1, 2'd1, 1'b0, 1'b0, 1'b0));
    checkOutput("sh_ale_req",   128'(data_sram_req), 128'(1'b0));
    checkOutput("sh_ale_valid", 128'(es_to_ms_valid), 128'(1'b1));
    checkOutput("sh_ale_bit",   128'(es_to_ms_bus[76]), 128'(1'b1));
    applyStimulus(makeDs(OP_ADD, 32'h1000, 1'b1, 32'h2, 32'h0, 1'b1, 5'd9, 1'b1,
                         1'b0, 2'd2, 1'b0, 1'b0, 1'b0));
    checkOutput("lw_ale", 128'({es_to_ms_bus[76], data_sram_req, es_to_ms_valid}),
                128'(3'b101));
    @(negedge clk);
    #1;

    $display("[TB] divider");
    runDiv("sdiv",   32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 32'hFFFF_FFFD);
    runDiv("smod",   32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 32'hFFFF_FFFF);
    runDiv("div0",   32'd9, 32'd0, 1'b0, 1'b0, 32'hFFFF_FFFF);
    runDiv("mod0",   32'd9, 32'd0, 1'b0, 1'b1, 32'd9);
    runDiv("ovf",    32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h8000_0000);
    runDiv("udiv",   32'd100, 32'd7, 1'b0, 1'b0, 32'd14);

    $display("[TB] reset during divide");
    applyStimulus(makeDs(12'h000, 32'd50, 1'b0, 32'h0, 32'd5, 1'b1, 5'd7, 1'b0, 1'b0, 2'd0,
                         1'b1, 1'b0, 1'b0));
    repeat (9) @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("rst_div_valid",   128'(es_to_ms_valid), 128'(1'b0));
    checkOutput("rst_div_allowin", 128'(es_allowin), 128'(1'b1));
    runDiv("post_rst", 32'd50, 32'd5, 1'b0, 1'b0, 32'd10);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
